// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, writeback select and sticky HALT tracking (optional MEM_WB_RETIRE_COUNT_EN retire counter)
module mem_wb_stage #(
    parameter int NB_WIDTH = 32,
    parameter int NB_REG   = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_WIDTH-1:0] i_read_data,
    input  logic [NB_WIDTH-1:0] i_alu_result,
    input  logic [NB_WIDTH-1:0] i_pc_plus8,
    input  logic [NB_REG-1:0]   i_rd,
    input  logic                i_reg_write_CU,
    input  logic [1:0]          i_wb_sel_CU,
    input  logic                i_halt_CU,
    output logic                o_reg_write,
    output logic [NB_REG-1:0]   o_wb_reg,
    output logic [NB_WIDTH-1:0] o_wb_data,
    output logic                o_fwd_valid,
`ifdef MEM_WB_RETIRE_COUNT_EN
    output logic [31:0]         o_retired,
`endif
    output logic                o_halt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t              state_q;
    logic                valid_q;
    logic [NB_WIDTH-1:0] read_data_q;
    logic [NB_WIDTH-1:0] alu_q;
    logic [NB_WIDTH-1:0] pc8_q;
    logic [NB_REG-1:0]   rd_q;
    logic                reg_write_q;
    logic [1:0]          wb_sel_q;
    logic                halt_q;

    // A flush overrides a stall, so the stage only truly holds on a stall without flush
    logic hold;
    assign hold = i_stall & ~i_flush;

    // A HALT sitting in the register already counts as halted, so it never writes back
    logic halted;
    assign halted = (state_q == HALTED) | (valid_q & halt_q);

    // Stage registers: reset clears, flush inserts a bubble, stall holds, otherwise load
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            valid_q     <= 1'b0;
            read_data_q <= '0;
            alu_q       <= '0;
            pc8_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= 2'b00;
            halt_q      <= 1'b0;
        end else if (i_flush || !i_stall) begin
            valid_q     <= i_valid & ~i_flush;
            read_data_q <= i_read_data;
            alu_q       <= i_alu_result;
            pc8_q       <= i_pc_plus8;
            rd_q        <= i_rd;
            reg_write_q <= i_reg_write_CU;
            wb_sel_q    <= i_wb_sel_CU;
            halt_q      <= i_halt_CU;
        end
    end

    // Halt state: enter once the valid HALT leaves the register; only reset returns to RUN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= RUN;
        end else if (!hold && state_q == RUN && valid_q && halt_q) begin
            state_q <= HALTED;
        end
    end

`ifdef MEM_WB_RETIRE_COUNT_EN
    // Retire counter: one count per valid instruction leaving the stage while running
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_retired <= 32'd0;
        end else if (valid_q && !hold && state_q == RUN) begin
            o_retired <= o_retired + 32'd1;
        end
    end
`endif

    // Writeback source mux on the registered fields
    always_comb begin
        o_wb_data = alu_q;
        case (wb_sel_q)
            2'b01:   o_wb_data = read_data_q;
            2'b10:   o_wb_data = pc8_q;
            default: o_wb_data = alu_q;
        endcase
    end

    assign o_wb_reg    = rd_q;
    assign o_reg_write = valid_q & reg_write_q & (rd_q != '0) & ~halted;
    assign o_fwd_valid = o_reg_write;
    assign o_halt      = halted;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage with behavioural model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid;
    logic [31:0] read_data, alu, pc8;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic        hlt;
    logic        reg_write, fwd_valid, halt_o;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
`ifdef MEM_WB_RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage #(.NB_WIDTH(32), .NB_REG(5)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_read_data(read_data), .i_alu_result(alu), .i_pc_plus8(pc8), .i_rd(rd),
        .i_reg_write_CU(rw), .i_wb_sel_CU(sel), .i_halt_CU(hlt),
        .o_reg_write(reg_write), .o_wb_reg(wb_reg), .o_wb_data(wb_data),
        .o_fwd_valid(fwd_valid),
`ifdef MEM_WB_RETIRE_COUNT_EN
        .o_retired(retired),
`endif
        .o_halt(halt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the instruction held in the stage plus halted flag and retire count
    bit          m_valid, m_rw, m_halt, m_known, m_halted;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_ret;

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a,
                                         input logic [31:0] r, input logic [31:0] p);
        if (s == 2'b01) return r;
        if (s == 2'b10) return p;
        return a;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 0; m_rw = 0; m_halt = 0; m_known = 1; m_halted = 0;
            m_rd = 0; m_data = 0; m_ret = 0;
        end else begin
            // the held instruction retires whenever the stage actually advances
            if (!(stall && !flush)) begin
                if (m_valid && !m_halted) m_ret = m_ret + 1;
                if (m_valid && m_halt) m_halted = 1;
            end
            if (flush) begin
                m_valid = 0; m_known = 0; m_halt = 0;
            end else if (!stall) begin
                m_valid = valid; m_rw = rw; m_halt = hlt; m_rd = rd;
                m_data = pick(sel, alu, read_data, pc8); m_known = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            bit h, w;
            h = m_halted || (m_valid && m_halt);
            w = m_valid && m_rw && (m_rd != 0) && !h;
            chk("model_halt", {31'd0, halt_o}, {31'd0, h});
            chk("model_reg_write", {31'd0, reg_write}, {31'd0, w});
            chk("model_fwd_valid", {31'd0, fwd_valid}, {31'd0, w});
            if (m_known) begin
                chk("model_wb_reg", {27'd0, wb_reg}, {27'd0, m_rd});
                chk("model_wb_data", wb_data, m_data);
            end
`ifdef MEM_WB_RETIRE_COUNT_EN
            chk("model_retired", retired, m_ret);
`endif
        end
    end

    task automatic drive(input bit v, input logic [4:0] d, input bit w, input logic [1:0] s,
                         input bit h, input logic [31:0] a, input logic [31:0] r,
                         input logic [31:0] p);
        valid = v; rd = d; rw = w; sel = s; hlt = h; alu = a; read_data = r; pc8 = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        drive(1, 5'd8, 1, 2'b00, 0, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);

        // reset with live inputs
        for (int i = 0; i < 2; i++) begin
            step();
            cmp_en = 1'b1;
            chk("reset_reg_write", {31'd0, reg_write}, 32'd0);
            chk("reset_wb_data", wb_data, 32'd0);
            chk("reset_halt", {31'd0, halt_o}, 32'd0);
        end
        rst_n = 1;

        // ALU writeback, then r0 suppression
        drive(1, 5'd8, 1, 2'b00, 0, 32'h0000_1234, 32'h0, 32'h0);
        step();
        chk("alu_reg_write", {31'd0, reg_write}, 32'd1);
        chk("alu_wb_reg", {27'd0, wb_reg}, 32'd8);
        chk("alu_wb_data", wb_data, 32'h0000_1234);
        drive(1, 5'd0, 1, 2'b00, 0, 32'h0000_1234, 32'h0, 32'h0);
        step();
        chk("r0_reg_write", {31'd0, reg_write}, 32'd0);

        // load and link writeback
        drive(1, 5'd9, 1, 2'b01, 0, 32'h0, 32'hFFFF_A5A5, 32'h0);
        step();
        chk("load_wb_data", wb_data, 32'hFFFF_A5A5);
        drive(1, 5'd31, 1, 2'b10, 0, 32'h0, 32'h0, 32'h0000_0108);
        step();
        chk("link_wb_data", wb_data, 32'h0000_0108);
        chk("link_wb_reg", {27'd0, wb_reg}, 32'd31);

        // stall holds, stall+flush bubbles
        drive(1, 5'd4, 1, 2'b00, 0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd6, 1, 2'b00, 0, $urandom, $urandom, $urandom);
            step();
            chk("stall_wb_data", wb_data, 32'hDEAD_BEEF);
        end
        flush = 1;
        step();
        chk("flush_reg_write", {31'd0, reg_write}, 32'd0);
        stall = 0; flush = 0;

        // halt is sticky until reset
        drive(1, 5'd7, 1, 2'b00, 1, 32'h0, 32'h0, 32'h0);
        step();
        chk("halt_set", {31'd0, halt_o}, 32'd1);
        chk("halt_no_write", {31'd0, reg_write}, 32'd0);
        drive(1, 5'd5, 1, 2'b00, 0, 32'h55, 32'h0, 32'h0);
        step();
        chk("halted_reg_write", {31'd0, reg_write}, 32'd0);
        chk("halted_sticky", {31'd0, halt_o}, 32'd1);
        rst_n = 0;
        step();
        chk("halt_cleared", {31'd0, halt_o}, 32'd0);
        rst_n = 1;

`ifdef MEM_WB_RETIRE_COUNT_EN
        // retire count: 4 instructions, 1 bubble, 2 stall cycles, then HALT
        drive(1, 5'd1, 1, 2'b00, 0, 32'h1, 32'h0, 32'h0); step();
        drive(1, 5'd2, 1, 2'b00, 0, 32'h2, 32'h0, 32'h0); step();
        drive(0, 5'd3, 1, 2'b00, 0, 32'h3, 32'h0, 32'h0); step();
        drive(1, 5'd3, 1, 2'b00, 0, 32'h3, 32'h0, 32'h0); step();
        drive(1, 5'd4, 1, 2'b00, 0, 32'h4, 32'h0, 32'h0);
        stall = 1; step(); step();
        stall = 0; step();
        drive(0, 5'd0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0); step();
        chk("retired_four", retired, 32'd4);
        drive(1, 5'd0, 0, 2'b00, 1, 32'h0, 32'h0, 32'h0); step();
        drive(0, 5'd0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0); step();
        chk("retired_halt", retired, 32'd5);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd9, 1, 2'b00, 0, $urandom, 32'h0, 32'h0);
            step();
        end
        chk("retired_hold", retired, 32'd5);
        rst_n = 0; step(); rst_n = 1;
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom_range(0, 40) == 0,
                  $urandom, $urandom, $urandom);
            step();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
